// File: rtl/uart_cmd_responder_if.sv
// ---------------------------------------------------------------------------
// uart_cmd_responder_if
//   Bundles the UART byte handshake and the register-bus signals of the
//   command responder.
//   Signals (directions as seen by the responder):
//     i_rx_data / i_rx_done   received byte and its 1-cycle valid tick
//     i_tx_done               1-cycle tick: previous tx byte finished
//     o_tx_data / o_tx_start  reply byte and its 1-cycle start pulse
//     o_reg_addr              register address (read and write)
//     o_reg_wr_data           register write data
//     o_reg_wr_en             1-cycle register write strobe
//     i_reg_rd_data           register read data
//     o_busy                  responder is inside a frame or reply
//     o_err                   1-cycle error pulse
//   Modports:
//     master  the responder (drives the register bus and the tx side)
//     slave   the environment (UART core plus register space)
// ---------------------------------------------------------------------------
interface uart_cmd_responder_if #(
  parameter int N_BITS    = 8,
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 5
);
  logic [N_BITS-1:0]    i_rx_data;
  logic                 i_rx_done;
  logic                 i_tx_done;
  logic [N_BITS-1:0]    o_tx_data;
  logic                 o_tx_start;
  logic [ADDR_BITS-1:0] o_reg_addr;
  logic [DATA_BITS-1:0] o_reg_wr_data;
  logic                 o_reg_wr_en;
  logic [DATA_BITS-1:0] i_reg_rd_data;
  logic                 o_busy;
  logic                 o_err;

  modport master (
    input  i_rx_data, i_rx_done, i_tx_done, i_reg_rd_data,
    output o_tx_data, o_tx_start, o_reg_addr, o_reg_wr_data, o_reg_wr_en,
           o_busy, o_err
  );

  modport slave (
    output i_rx_data, i_rx_done, i_tx_done, i_reg_rd_data,
    input  o_tx_data, o_tx_start, o_reg_addr, o_reg_wr_data, o_reg_wr_en,
           o_busy, o_err
  );
endinterface

// File: rtl/uart_cmd_responder.sv
// ---------------------------------------------------------------------------
// uart_cmd_responder
//   Host-facing end of the UART link. Parses READ (0x01, ADDR) and
//   WRITE (0x02, ADDR, D0..Dn, LSB first) frames from received bytes, issues
//   register-bus reads/writes and sends reply bytes through the tx
//   start/done handshake.
//     READ  -> DATA_BITS/N_BITS reply bytes of the register, LSB first
//     WRITE -> one write strobe, reply 0xAA
//     bad opcode / bad address -> reply 0xEE with an o_err pulse
//     inter-byte silence of TIMEOUT_CYCLES inside a frame -> o_err, no reply
//   Ports:
//     i_clock  system clock
//     i_reset  asynchronous, active-high reset
//     bus      uart_cmd_responder_if.master (UART byte and register bus side)
// ---------------------------------------------------------------------------
module uart_cmd_responder #(
  parameter int N_BITS         = 8,
  parameter int DATA_BITS      = 32,
  parameter int ADDR_BITS      = 5,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  uart_cmd_responder_if.master  bus
);

  localparam int N_BYTES = DATA_BITS / N_BITS;
  localparam int CNT_W   = $clog2(N_BYTES + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [N_BITS-1:0] OP_READ   = N_BITS'(8'h01);
  localparam logic [N_BITS-1:0] OP_WRITE  = N_BITS'(8'h02);
  localparam logic [N_BITS-1:0] REPLY_ACK = N_BITS'(8'hAA);
  localparam logic [N_BITS-1:0] REPLY_ERR = N_BITS'(8'hEE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_DATA,
    S_WR_STROBE,
    S_RD_FETCH,
    S_LOAD_REPLY,
    S_WAIT_TX
  } state_t;

  state_t               state_q,      state_d;
  logic                 is_write_q,   is_write_d;
  logic                 addr_bad_q,   addr_bad_d;
  logic [ADDR_BITS-1:0] addr_q,       addr_d;
  logic [DATA_BITS-1:0] wr_data_q,    wr_data_d;
  logic [DATA_BITS-1:0] shift_q,      shift_d;
  logic [CNT_W-1:0]     byte_cnt_q,   byte_cnt_d;
  logic [CNT_W-1:0]     reply_left_q, reply_left_d;
  logic [TO_W-1:0]      tout_q,       tout_d;
  logic [N_BITS-1:0]    tx_data_q,    tx_data_d;
  logic                 err_q,        err_d;

  logic                 tout_hit;
  logic                 rx_addr_bad;

  assign tout_hit    = (tout_q == TO_W'(TIMEOUT_CYCLES - 1));
  // Any set bit above the implemented address width makes the address invalid.
  assign rx_addr_bad = ((bus.i_rx_data >> ADDR_BITS) != '0);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      is_write_q   <= 1'b0;
      addr_bad_q   <= 1'b0;
      addr_q       <= '0;
      wr_data_q    <= '0;
      shift_q      <= '0;
      byte_cnt_q   <= '0;
      reply_left_q <= '0;
      tout_q       <= '0;
      tx_data_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_write_q   <= is_write_d;
      addr_bad_q   <= addr_bad_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      shift_q      <= shift_d;
      byte_cnt_q   <= byte_cnt_d;
      reply_left_q <= reply_left_d;
      tout_q       <= tout_d;
      tx_data_q    <= tx_data_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    is_write_d   = is_write_q;
    addr_bad_d   = addr_bad_q;
    addr_d       = addr_q;
    wr_data_d    = wr_data_q;
    shift_d      = shift_q;
    byte_cnt_d   = byte_cnt_q;
    reply_left_d = reply_left_q;
    tout_d       = '0;
    tx_data_d    = tx_data_q;
    err_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        byte_cnt_d = '0;
        if (bus.i_rx_done) begin
          if (bus.i_rx_data == OP_READ || bus.i_rx_data == OP_WRITE) begin
            is_write_d = (bus.i_rx_data == OP_WRITE);
            state_d    = S_GET_ADDR;
          end else begin
            tx_data_d    = REPLY_ERR;
            reply_left_d = '0;
            err_d        = 1'b1;
            state_d      = S_LOAD_REPLY;
          end
        end
      end

      S_GET_ADDR: begin
        if (bus.i_rx_done) begin
          addr_d     = bus.i_rx_data[ADDR_BITS-1:0];
          addr_bad_d = rx_addr_bad;
          err_d      = rx_addr_bad;
          if (is_write_q) begin
            // A bad-address write still swallows its data bytes so the
            // link stays aligned to frame boundaries.
            byte_cnt_d = '0;
            state_d    = S_GET_DATA;
          end else if (rx_addr_bad) begin
            tx_data_d    = REPLY_ERR;
            reply_left_d = '0;
            state_d      = S_LOAD_REPLY;
          end else begin
            state_d = S_RD_FETCH;
          end
        end else if (tout_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tout_d = tout_q + TO_W'(1);
        end
      end

      S_GET_DATA: begin
        // Completion is judged from the registered byte count, so the strobe
        // state follows one cycle after the last data byte has landed.
        if (byte_cnt_q == CNT_W'(N_BYTES)) begin
          state_d = S_WR_STROBE;
        end else if (bus.i_rx_done) begin
          for (int k = 0; k < N_BYTES; k++) begin
            if (byte_cnt_q == CNT_W'(k)) begin
              wr_data_d[k*N_BITS +: N_BITS] = bus.i_rx_data;
            end
          end
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
        end else if (tout_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tout_d = tout_q + TO_W'(1);
        end
      end

      S_WR_STROBE: begin
        tx_data_d    = addr_bad_q ? REPLY_ERR : REPLY_ACK;
        reply_left_d = '0;
        state_d      = S_LOAD_REPLY;
      end

      S_RD_FETCH: begin
        // Address has been stable for this whole cycle, so read data is valid.
        shift_d      = bus.i_reg_rd_data;
        tx_data_d    = bus.i_reg_rd_data[N_BITS-1:0];
        reply_left_d = CNT_W'(N_BYTES - 1);
        state_d      = S_LOAD_REPLY;
      end

      S_LOAD_REPLY: begin
        state_d = S_WAIT_TX;
      end

      S_WAIT_TX: begin
        if (bus.i_tx_done) begin
          if (reply_left_q != '0) begin
            shift_d      = shift_q >> N_BITS;
            tx_data_d    = shift_d[N_BITS-1:0];
            reply_left_d = reply_left_q - CNT_W'(1);
            state_d      = S_LOAD_REPLY;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.o_tx_data     = tx_data_q;
  assign bus.o_tx_start    = (state_q == S_LOAD_REPLY);
  assign bus.o_reg_addr    = addr_q;
  assign bus.o_reg_wr_data = wr_data_q;
  assign bus.o_reg_wr_en   = (state_q == S_WR_STROBE) && !addr_bad_q;
  assign bus.o_busy        = (state_q != S_IDLE);
  assign bus.o_err         = err_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_responder
//   Directed bench for uart_cmd_responder: READ, WRITE, bad opcode,
//   bad-address write, inter-byte timeout and reset in the middle of a reply.
//   The bench answers every tx start with a tx_done about 10 clocks later.
// ---------------------------------------------------------------------------
module tb_uart_cmd_responder;

  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_cmd_responder_if #(.N_BITS(8), .DATA_BITS(32), .ADDR_BITS(5)) bus ();

  uart_cmd_responder #(
    .N_BITS(8), .DATA_BITS(32), .ADDR_BITS(5), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Event monitor: counts strobes/pulses and records the last write.
  int          wr_cnt = 0;
  int          err_cnt = 0;
  int          start_cnt = 0;
  logic [4:0]  wr_addr_seen = '0;
  logic [31:0] wr_data_seen = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_reg_wr_en === 1'b1) begin
        wr_cnt       <= wr_cnt + 1;
        wr_addr_seen <= bus.o_reg_addr;
        wr_data_seen <= bus.o_reg_wr_data;
      end
      if (bus.o_err === 1'b1)      err_cnt   <= err_cnt + 1;
      if (bus.o_tx_start === 1'b1) start_cnt <= start_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    tick();
    bus.i_rx_done = 1'b0;
  endtask

  // Waits (bounded) for a tx start; k = negedges counted, -1 if none came.
  task automatic wait_start(output int k, output logic [7:0] d);
    k = -1;
    d = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.o_tx_start === 1'b1) begin
        k = i;
        d = bus.o_tx_data;
        break;
      end
    end
  endtask

  task automatic finish_tx(input string tag, input logic [7:0] d);
    tick();
    repeat (8) tick();
    chk({tag, "_hold"}, bus.o_tx_data, d);
    bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
  endtask

  task automatic recv_byte(input string tag, input int exp_k, input logic [7:0] exp_d);
    int k;
    logic [7:0] d;
    wait_start(k, d);
    chk({tag, "_lat"}, k, exp_k);
    chk({tag, "_data"}, d, exp_d);
    if (k > 0) finish_tx(tag, d);
  endtask

  task automatic read_frame(input string tag, input logic [7:0] addr, input logic [31:0] word);
    bus.i_reg_rd_data = word;
    send_byte(8'h01);
    send_byte(addr);
    for (int i = 0; i < 4; i++) begin
      recv_byte($sformatf("%s_b%0d", tag, i), (i == 0) ? 2 : 1, word[8*i +: 8]);
    end
    @(negedge clk);
    chk({tag, "_busy_end"}, bus.o_busy, 1'b0);
  endtask

  initial begin
    int wr0, err0, st0;
    int k;
    logic [7:0] d;

    bus.i_rx_data     = '0;
    bus.i_rx_done     = 1'b0;
    bus.i_tx_done     = 1'b0;
    bus.i_reg_rd_data = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_tx_start", bus.o_tx_start, 1'b0);
    chk("rst_tx_data", bus.o_tx_data, 8'h00);
    chk("rst_addr", bus.o_reg_addr, 5'h00);
    chk("rst_wr_data", bus.o_reg_wr_data, 32'h0);
    chk("rst_wr_en", bus.o_reg_wr_en, 1'b0);
    chk("rst_busy", bus.o_busy, 1'b0);
    chk("rst_err", bus.o_err, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // 1: READ 0x03 of 0xDEADBEEF
    $display("step 1: READ addr 0x03");
    wr0 = wr_cnt; err0 = err_cnt; st0 = start_cnt;
    bus.i_reg_rd_data = 32'hDEADBEEF;
    send_byte(8'h01);
    @(negedge clk);
    chk("t1_busy_mid", bus.o_busy, 1'b1);
    send_byte(8'h03);
    for (int i = 0; i < 4; i++) begin
      recv_byte($sformatf("t1_b%0d", i), (i == 0) ? 2 : 1, (i == 0) ? 8'hEF : (i == 1) ? 8'hBE : (i == 2) ? 8'hAD : 8'hDE);
    end
    @(negedge clk);
    chk("t1_busy_end", bus.o_busy, 1'b0);
    chk("t1_addr", bus.o_reg_addr, 5'd3);
    repeat (5) tick();
    chk("t1_no_wr", wr_cnt - wr0, 0);
    chk("t1_no_err", err_cnt - err0, 0);
    chk("t1_starts", start_cnt - st0, 4);

    // 2: WRITE 0x07 <- 0x11223344
    $display("step 2: WRITE addr 0x07 data 0x11223344");
    wr0 = wr_cnt; err0 = err_cnt;
    send_byte(8'h02); send_byte(8'h07);
    send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
    recv_byte("t2_ack", 3, 8'hAA);
    @(negedge clk);
    chk("t2_busy_end", bus.o_busy, 1'b0);
    chk("t2_wr_pulses", wr_cnt - wr0, 1);
    chk("t2_wr_addr", wr_addr_seen, 5'd7);
    chk("t2_wr_data", wr_data_seen, 32'h11223344);
    chk("t2_no_err", err_cnt - err0, 0);

    // 3: bad opcode, then a normal READ
    $display("step 3: bad opcode 0x5A then READ addr 0x1F");
    err0 = err_cnt;
    send_byte(8'h5A);
    recv_byte("t3_nak", 1, 8'hEE);
    chk("t3_err", err_cnt - err0, 1);
    read_frame("t3_rd", 8'h1F, 32'h0BADF00D);
    chk("t3_addr", bus.o_reg_addr, 5'h1F);

    // 4: WRITE to bad address 0x25
    $display("step 4: WRITE bad addr 0x25");
    wr0 = wr_cnt; err0 = err_cnt;
    send_byte(8'h02); send_byte(8'h25);
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
    recv_byte("t4_nak", 3, 8'hEE);
    chk("t4_no_wr", wr_cnt - wr0, 0);
    chk("t4_err", err_cnt - err0, 1);

    // 5: inter-byte timeout inside a WRITE
    $display("step 5: WRITE stalls after one data byte");
    wr0 = wr_cnt; err0 = err_cnt; st0 = start_cnt;
    send_byte(8'h02); send_byte(8'h01); send_byte(8'h10);
    repeat (TO - 3) tick();
    @(negedge clk);
    chk("t5_busy_before", bus.o_busy, 1'b1);
    chk("t5_no_err_yet", err_cnt - err0, 0);
    repeat (6) tick();
    @(negedge clk);
    chk("t5_busy_after", bus.o_busy, 1'b0);
    chk("t5_err", err_cnt - err0, 1);
    chk("t5_no_start", start_cnt - st0, 0);
    chk("t5_no_wr", wr_cnt - wr0, 0);

    // 6: reset while the 2nd READ reply byte is in flight
    $display("step 6: reset during READ reply");
    wr0 = wr_cnt;
    bus.i_reg_rd_data = 32'hDEADBEEF;
    send_byte(8'h01); send_byte(8'h03);
    recv_byte("t6_b0", 2, 8'hEF);
    wait_start(k, d);
    chk("t6_b1_lat", k, 1);
    chk("t6_b1_data", d, 8'hBE);
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", bus.o_busy, 1'b0);
    chk("t6_rst_tx_data", bus.o_tx_data, 8'h00);
    chk("t6_rst_tx_start", bus.o_tx_start, 1'b0);
    chk("t6_rst_addr", bus.o_reg_addr, 5'h00);
    chk("t6_rst_wr_data", bus.o_reg_wr_data, 32'h0);
    chk("t6_rst_err", bus.o_err, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();
    read_frame("t6_rd", 8'h05, 32'h12345678);
    chk("t6_addr", bus.o_reg_addr, 5'd5);
    chk("t6_no_wr", wr_cnt - wr0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no end of test, required finish before 400000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
